// File: rtl/lsu_mem_adapter_if.sv
// Bundle of core-side request/response and memory-controller signals
// for the LSU memory adapter.
interface lsu_mem_adapter_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_wen;
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata,
        input  req_size, req_unsigned, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_valid, mem_wen, mem_raddr, mem_waddr,
        output mem_wdata, mem_wmask
    );

    modport master (
        output req_valid, req_wen, req_addr, req_wdata,
        output req_size, req_unsigned, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_valid, mem_wen, mem_raddr, mem_waddr,
        input  mem_wdata, mem_wmask
    );
endinterface

// File: rtl/lsu_mem_adapter.sv
// Single-outstanding LSU to word-memory adapter: lane shifting for stores,
// alignment check, and extended loads after a fixed read latency.
module lsu_mem_adapter #(
    parameter int LATENCY = 1
) (
    input logic              clk,
    input logic              reset,
    lsu_mem_adapter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_n;
    logic        wen_q, uns_q, err_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [1:0]  size_q;
    logic [2:0]  cnt;
    logic        misal, accept, last;
    logic [1:0]  off;
    logic [3:0]  base;
    logic [31:0] d, ld;

    assign off    = addr_q[1:0];
    assign accept = (state == IDLE) && bus.req_valid;
    assign last   = (state == ACCESS) && (wen_q || cnt == 3'd1);

    always_comb begin
        misal = (bus.req_size == 2'd3)
             || (bus.req_size == 2'd1 && bus.req_addr[0])
             || (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'd0);
    end

    always_comb begin
        d  = bus.mem_rdata >> {off, 3'b000};
        ld = d;
        case (size_q)
            2'd0:    ld = {{24{~uns_q & d[7]}}, d[7:0]};
            2'd1:    ld = {{16{~uns_q & d[15]}}, d[15:0]};
            default: ld = d;
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0:    base = 4'b0001;
            2'd1:    base = 4'b0011;
            default: base = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n        = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'd0;
        bus.resp_err   = 1'b0;
        bus.mem_valid  = 1'b0;
        bus.mem_wen    = 1'b0;
        bus.mem_raddr  = 32'd0;
        bus.mem_waddr  = 32'd0;
        bus.mem_wdata  = 32'd0;
        bus.mem_wmask  = 8'd0;
        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_n = misal ? RESP : ACCESS;
            end
            ACCESS: begin
                bus.mem_valid = 1'b1;
                bus.mem_raddr = {addr_q[31:2], 2'b00};
                bus.mem_waddr = {addr_q[31:2], 2'b00};
                if (wen_q) begin
                    bus.mem_wen   = 1'b1;
                    bus.mem_wdata = wdata_q << {off, 3'b000};
                    bus.mem_wmask = {4'b0000, base << off};
                end
                if (last) state_n = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = rdata_q;
                bus.resp_err   = err_q;
                if (bus.resp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request fields are captured only on the IDLE handshake edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'd0;
            rdata_q <= 32'd0;
            cnt     <= 3'd0;
        end else if (accept) begin
            wen_q   <= bus.req_wen;
            uns_q   <= bus.req_unsigned;
            err_q   <= misal;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            size_q  <= bus.req_size;
            rdata_q <= 32'd0;
            cnt     <= misal ? 3'd0 : 3'(LATENCY);
        end else if (state == ACCESS) begin
            if (last) begin
                rdata_q <= wen_q ? 32'd0 : ld;
                cnt     <= 3'd0;
            end else begin
                cnt <= cnt - 3'd1;
            end
        end
    end
endmodule

// File: doc/lsu_mem_adapter.md
LSU_MEM_ADAPTER -- requirements
Module: lsu_mem_adapter

Interface
REQ-001 SHALL have parameter LATENCY, default 1: cycles mem_valid is held for a load before mem_rdata is sampled; legal range 1..7.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have req_valid  input  1  core request present.
REQ-005 SHALL have req_ready  output  1  adapter accepts request this cycle.
REQ-006 SHALL have req_wen  input  1  1=store, 0=load.
REQ-007 SHALL have req_addr  input  32  byte address.
REQ-008 SHALL have req_wdata  input  32  store data, right-aligned.
REQ-009 SHALL have req_size  input  2  0=byte, 1=half, 2=word, 3=illegal.
REQ-010 SHALL have req_unsigned  input  1  zero-extend load when 1, sign-extend when 0.
REQ-011 SHALL have resp_valid  output  1  response present.
REQ-012 SHALL have resp_ready  input  1  core consumes response.
REQ-013 SHALL have resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have resp_err  output  1  misaligned/illegal access.
REQ-015 SHALL have mem_valid, mem_wen  output  1 each  memory-controller strobe and write enable.
REQ-016 SHALL have mem_raddr, mem_waddr, mem_wdata  output  32 each  word-aligned addresses and lane-shifted store data.
REQ-017 SHALL have mem_wmask  output  8  byte-lane mask, bits 7:4 always 0.
REQ-018 SHALL have mem_rdata  input  32  word read from memory controller.

Function
REQ-019 SHALL implement FSM IDLE, ACCESS, RESP; one request outstanding at a time, no pipelining.
REQ-020 SHALL drive req_ready=1 only in IDLE; handshake is req_valid&req_ready at a rising edge, latching wen, addr, wdata, size, unsigned.
REQ-021 SHALL flag misaligned when size=1 & addr[0]=1, size=2 & addr[1:0]!=0, or size=3; such requests go IDLE->RESP with resp_err=1, resp_rdata=0, and no memory cycle.
REQ-022 SHALL otherwise go IDLE->ACCESS; off=addr[1:0].
REQ-023 SHALL in ACCESS drive mem_valid=1, mem_raddr=mem_waddr={addr[31:2],2'b00}.
REQ-024 SHALL for stores drive mem_wen=1, mem_wdata=wdata<<(8*off), mem_wmask={4'b0, base<<off} with base 0001/0011/1111 for byte/half/word; ACCESS lasts exactly 1 cycle, then RESP (write issued exactly once).
REQ-025 SHALL for loads drive mem_wen=0, mem_wdata=0, mem_wmask=0 and hold ACCESS for exactly LATENCY cycles via a 3-bit down-counter; mem_rdata sampled at the clock edge ending the last ACCESS cycle, then RESP.
REQ-026 SHALL form load data as d=mem_rdata>>(8*off), then byte d[7:0] / half d[15:0] extended to 32 bits per req_unsigned; word passes unchanged.
REQ-027 SHALL in RESP hold resp_valid=1 and stable resp_rdata/resp_err until resp_ready=1, then return to IDLE next cycle; req_ready stays 0 during RESP even if resp_ready=1.
REQ-028 SHALL drive all mem_* outputs to 0 outside ACCESS.
REQ-029 SHALL ignore req_* inputs outside the IDLE handshake cycle; changes during ACCESS/RESP have no effect.

Reset
REQ-030 SHALL on reset force IDLE immediately (asynchronously): req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, all mem_* =0, counter=0.
REQ-031 SHALL on reset mid-ACCESS/RESP abandon the transaction: mem_valid drops in the same cycle, no response issued after reset release.

Verification
REQ-032 SHALL cover store byte: addr=0x80000003, wdata=0xAB, size=0 -> one cycle mem_valid=1, mem_wen=1, mem_waddr=0x80000000, mem_wdata=0xAB000000, mem_wmask=0x08; then resp_valid, resp_err=0.
REQ-033 SHALL cover signed half load, LATENCY=3: addr=0x80000002, mem_rdata=0x8001_1234 -> mem_valid high 3 cycles, resp_rdata=0xFFFF8001; with req_unsigned=1 -> 0x00008001.
REQ-034 SHALL cover misaligned word load addr=0x80000001 -> mem_valid never asserts, resp_err=1, resp_rdata=0 one cycle after handshake.
REQ-035 SHALL cover response backpressure: resp_ready=0 for 5 cycles -> resp_valid and data held stable, req_ready=0; resp_ready=1 -> IDLE next cycle.
REQ-036 SHALL cover reset asserted in 2nd ACCESS cycle of a LATENCY=3 load -> mem_valid=0 same cycle, no resp_valid after release, req_ready=1.
